vending_machine_multi: RTL
==========================

# vending_machine_multi

Parametrised successor to the single-product 50/100 rs vending FSM. It accumulates credit from 50 rs and 100 rs coins and serves one of N_PROD products at per-product prices, with stock-empty checks. Change is returned coin by coin, one coin per cycle. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

## Interface
- N_PROD, 4, number of selectable products (≥2)
- CREDIT_W, 4, credit/price width in 50 rs units
- MAX_CREDIT, 10, credit ceiling in units; must be < 2^CREDIT_W
- SEL_W, $clog2(N_PROD), product index width (localparam)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- coin  in  2  01=50 rs (1 unit), 10=100 rs (2 units), 00=none, 11=invalid
- sel_valid  in  1  product selection strobe, sampled each clk
- sel_id  in  SEL_W  selected product index
- cancel  in  1  refund request
- price_tbl  in  N_PROD*CREDIT_W  packed prices, product i at [i*CREDIT_W +: CREDIT_W]
- stock_empty  in  N_PROD  1 = product i sold out
- vend  out  1  1-cycle dispense pulse
- vend_id  out  SEL_W  product dispensed, valid with vend
- change  out  2  coin returned this cycle: 01=50 rs, 10=100 rs, 00=none
- coin_reject  out  1  1-cycle pulse: coin input sent straight to return chute
- sel_reject  out  1  1-cycle pulse: selection refused
- credit  out  CREDIT_W  current credit in units
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE, CREDIT, VEND, CHANGE. Encoding is implementation choice.
- IDLE (credit=0): valid coin → credit=value, go CREDIT. coin=11 → coin_reject. sel_valid → sel_reject. cancel ignored.
- CREDIT, priority per cycle: cancel > sel_valid > coin.
  - cancel → CHANGE. A coin in the same cycle gets coin_reject.
  - sel_valid: refused (sel_reject, stay) if sel_id ≥ N_PROD, stock_empty[sel_id]=1, or price > credit. Otherwise credit -= price, vend=1, vend_id=sel_id, go VEND. A coin in the same cycle gets coin_reject.
  - coin: accepted if credit+value ≤ MAX_CREDIT (compare at CREDIT_W+1 bits), else coin_reject. coin=11 → coin_reject.
- VEND: one cycle, all inputs ignored, any coin gets coin_reject. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: one coin per cycle. credit ≥ 2 → change=10, credit -= 2. credit = 1 → change=01, credit = 0. Go IDLE in the cycle credit reaches 0. Coins get coin_reject; sel_valid and cancel are ignored.
- Zero-price product: valid; vends with no credit deduction, but only from CREDIT.
- Credit never exceeds MAX_CREDIT and never underflows.

## Timing
- All outputs are registered and update on the clk edge that samples the causing input. They are visible for exactly the following cycle. Pulses are 1 cycle.
- Selection → vend: 1 cycle. vend → first change coin: 1 cycle (the VEND cycle).
- Refund of C units takes ceil(C/2) consecutive change cycles. busy is high throughout, and falls with the transition to IDLE.
- rst low (async): state=IDLE, credit=0, vend=0, vend_id=0, change=00, coin_reject=0, sel_reject=0, busy=0 immediately. Mid-CHANGE reset discards the remaining credit; no further coins are returned.
- price_tbl and stock_empty are sampled only on a selection cycle; they may change freely otherwise.

## Test plan
- Reset: hold rst=0 mid-CHANGE with credit=5 → all outputs 0 within the same cycle; after release, IDLE with credit=0.
- Coins 01,10,10 (5 units), sel_id=2 price=3 → vend pulse, vend_id=2, then change=10 for one cycle, busy drops, IDLE.
- MAX_CREDIT=10: five 10 coins, then 01 → coin_reject pulse, credit stays 10. Then cancel → change 10 ×5 over 5 cycles, then IDLE.
- Selection with price 4 and credit 3 → sel_reject, credit 3 held. Same with stock_empty[1]=1 and enough credit → sel_reject, no vend.
- Same cycle cancel+sel_valid+coin=01 at credit 3 → no vend, coin_reject, refund 10 then 01.
- Coin=10 during VEND and CHANGE, and coin=11 in CREDIT → coin_reject each time, credit unchanged.

Source files
------------

// File: rtl/vending_machine_multi.sv
// vending_machine_multi
// Multi-product vending controller. It accumulates credit in 50 rs units from
// 50 rs and 100 rs coins and serves one of N_PROD products at per-product
// prices, refusing sold-out products. Remaining credit is returned as change,
// one coin per cycle. All outputs are registered.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   coin         01 = 50 rs, 10 = 100 rs, 00 = none, 11 = invalid
//   sel_valid    product selection strobe
//   sel_id       selected product index
//   cancel       refund request
//   price_tbl    packed prices, product i at [i*CREDIT_W +: CREDIT_W]
//   stock_empty  1 = product i sold out
//   vend         1-cycle dispense pulse
//   vend_id      product dispensed, valid with vend
//   change       coin returned this cycle (01 = 50 rs, 10 = 100 rs)
//   coin_reject  1-cycle pulse: coin routed to the return chute
//   sel_reject   1-cycle pulse: selection refused
//   credit       current credit in units
//   busy         high while vending or returning change
module vending_machine_multi #(
   parameter int unsigned N_PROD     = 4,
   parameter int unsigned CREDIT_W   = 4,
   parameter int unsigned MAX_CREDIT = 10,
   localparam int unsigned SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 coin,
   input  logic                       sel_valid,
   input  logic [SEL_W-1:0]           sel_id,
   input  logic                       cancel,
   input  logic [N_PROD*CREDIT_W-1:0] price_tbl,
   input  logic [N_PROD-1:0]          stock_empty,
   output logic                       vend,
   output logic [SEL_W-1:0]           vend_id,
   output logic [1:0]                 change,
   output logic                       coin_reject,
   output logic                       sel_reject,
   output logic [CREDIT_W-1:0]        credit,
   output logic                       busy
);

   typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

   state_e state;

   logic                coin_ok;
   logic                coin_any;
   logic [CREDIT_W:0]   coin_units;
   logic [CREDIT_W:0]   coin_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] sel_price;
   logic                sel_in_range;
   logic                sel_ok;

   always_comb begin
      coin_units = '0;
      coin_ok    = 1'b0;
      unique case (coin)
         2'b01: begin
            coin_units = (CREDIT_W+1)'(1);
            coin_ok    = 1'b1;
         end
         2'b10: begin
            coin_units = (CREDIT_W+1)'(2);
            coin_ok    = 1'b1;
         end
         default: ;
      endcase
      coin_any  = (coin != 2'b00);
      // One extra bit so the ceiling check cannot wrap.
      coin_sum  = {1'b0, credit} + coin_units;
      coin_fits = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

      sel_in_range = (32'(sel_id) < N_PROD);
      sel_price    = '0;
      sel_ok       = 1'b0;
      if (sel_in_range) begin
         sel_price = price_tbl[sel_id*CREDIT_W +: CREDIT_W];
         sel_ok    = !stock_empty[sel_id] && (sel_price <= credit);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StIdle;
         credit      <= '0;
         vend        <= 1'b0;
         vend_id     <= '0;
         change      <= 2'b00;
         coin_reject <= 1'b0;
         sel_reject  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         vend        <= 1'b0;
         change      <= 2'b00;
         coin_reject <= 1'b0;
         sel_reject  <= 1'b0;

         unique case (state)
            StIdle: begin
               if (coin_ok) begin
                  credit <= coin_units[CREDIT_W-1:0];
                  state  <= StCredit;
               end else if (coin_any) begin
                  coin_reject <= 1'b1;
               end
               // Nothing can be bought without credit, zero-price included.
               if (sel_valid) sel_reject <= 1'b1;
               busy <= 1'b0;
            end

            StCredit: begin
               if (cancel) begin
                  state <= StChange;
                  busy  <= 1'b1;
                  if (coin_any) coin_reject <= 1'b1;
               end else if (sel_valid) begin
                  // The selection owns this cycle; a coin arriving with it is returned.
                  if (coin_any) coin_reject <= 1'b1;
                  if (sel_ok) begin
                     credit  <= credit - sel_price;
                     vend    <= 1'b1;
                     vend_id <= sel_id;
                     state   <= StVend;
                     busy    <= 1'b1;
                  end else begin
                     sel_reject <= 1'b1;
                  end
               end else if (coin_ok && coin_fits) begin
                  credit <= coin_sum[CREDIT_W-1:0];
               end else if (coin_any) begin
                  coin_reject <= 1'b1;
               end
            end

            StVend: begin
               if (coin_any) coin_reject <= 1'b1;
               if (credit != '0) begin
                  state <= StChange;
                  busy  <= 1'b1;
               end else begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end

            StChange: begin
               if (coin_any) coin_reject <= 1'b1;
               if (credit >= CREDIT_W'(2)) begin
                  change <= 2'b10;
                  credit <= credit - CREDIT_W'(2);
               end else if (credit == CREDIT_W'(1)) begin
                  change <= 2'b01;
                  credit <= '0;
               end
               // Leave on the same edge that returns the last coin.
               if (credit <= CREDIT_W'(2)) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
